// File: rtl/module_display_scan.sv
// Four-digit multiplexed hex display scanner with double-buffered data capture.
// New values are held in a pending register and swapped in only at frame end, so a frame never tears.
module module_display_scan #(
    parameter int DIV = 6750
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    input  logic        blank_lz,
    output logic [3:0]  digit,
    output logic [3:0]  anodes,
    output logic        pending,
    output logic        frame
);

    localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [15:0] disp;
    logic [15:0] pend;
    logic        pend_v;

    logic        last;
    logic        frame_c;
    logic [3:0]  upper_zero;
    logic        blanked;

    assign last    = (cnt == CNT_LAST);
    assign frame_c = en && (idx == 2'd3) && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            idx    <= '0;
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
        end else begin
            if (en) begin
                if (last) begin
                    cnt <= '0;
                    idx <= idx + 2'd1;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
            // A load landing on the frame cycle bypasses pend: the newest value wins.
            if (frame_c) begin
                if (load)
                    disp <= data;
                else if (pend_v)
                    disp <= pend;
                pend_v <= 1'b0;
            end else if (load) begin
                pend   <= data;
                pend_v <= 1'b1;
            end
        end
    end

    // upper_zero[k]: disp nibbles k..3 are all zero.
    for (genvar k = 0; k < 4; k++) begin : g_lz
        assign upper_zero[k] = ((disp >> (4 * k)) == 16'd0);
    end

    assign blanked = blank_lz && (idx != 2'd0) && upper_zero[idx];
    assign digit   = disp[{idx, 2'b00} +: 4];
    assign anodes  = (!en || blanked) ? 4'b1111 : ~(4'b0001 << idx);
    assign frame   = frame_c;
    assign pending = pend_v;

endmodule

// File: tb/tb_module_display_scan.sv
// Bench for module_display_scan: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a position-based reference model.
module tb_module_display_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic        blank_lz;
    logic [3:0]  digit;
    logic [3:0]  anodes;
    logic        pending;
    logic        frame;

    int nvec = 0;
    int nerr = 0;

    module_display_scan #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .data     (data),
        .blank_lz (blank_lz),
        .digit    (digit),
        .anodes   (anodes),
        .pending  (pending),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: scan position within the frame, shown value, newest pending value.
    int          mpos   = 0;
    logic [15:0] mshown = '0;
    logic [15:0] mpval  = '0;
    bit          mpv    = 1'b0;
    bit          chk_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mpos   = 0;
            mshown = '0;
            mpval  = '0;
            mpv    = 1'b0;
            chk_on = 1'b1;
        end else begin
            if (en && mpos == FRAME - 1) begin
                if (load)
                    mshown = data;
                else if (mpv)
                    mshown = mpval;
                mpv = 1'b0;
            end else if (load) begin
                mpval = data;
                mpv   = 1'b1;
            end
            if (en)
                mpos = (mpos + 1) % FRAME;
        end
    end

    always @(negedge clk) begin : compare
        int          k;
        logic [15:0] above;
        bit          blk;
        logic [3:0]  ea;
        if (chk_on) begin
            k     = mpos / DIV;
            above = mshown >> (4 * k);
            blk   = blank_lz && (k > 0) && (above == 16'd0);
            ea    = (!en || blk) ? 4'hF : (4'hF ^ (4'h1 << k));
            chk("digit",   {12'd0, digit},   {12'd0, above[3:0]});
            chk("anodes",  {12'd0, anodes},  {12'd0, ea});
            chk("pending", {15'd0, pending}, {15'd0, mpv});
            chk("frame",   {15'd0, frame},   {15'd0, (en && mpos == FRAME - 1)});
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        cyc();
        rst  = 1'b0;
    endtask

    logic [3:0]  scan_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0]  lz70_tab [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [15:0] val;

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; data = '0; blank_lz = 1'b0;
        cyc();

        // Plain scan after reset
        en = 1'b1;
        do_reset();
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            chk("scan_anodes", {12'd0, anodes}, {12'd0, scan_tab[(i / DIV) % 4]});
            chk("scan_frame",  {15'd0, frame},  {15'd0, (i == FRAME - 1)});
            if (i == 0) begin
                chk("rst_digit",   {12'd0, digit},   16'd0);
                chk("rst_pending", {15'd0, pending}, 16'd0);
            end
            cyc();
        end

        // Load mid-frame, shown only after the frame boundary
        do_reset();
        repeat (5) cyc();
        load = 1'b1; data = 16'h12AF;
        cyc();
        load = 1'b0;
        @(negedge clk);
        chk("mid_pending", {15'd0, pending}, 16'd1);
        chk("mid_digit",   {12'd0, digit},   16'd0);
        repeat (10) cyc();
        val = 16'h12AF;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("load_digit",  {12'd0, digit},   {12'd0, val[4*j +: 4]});
            chk("load_pend0",  {15'd0, pending}, 16'd0);
            repeat (DIV) cyc();
        end

        // Overwrite then collision with the frame cycle
        do_reset();
        repeat (3) cyc();
        load = 1'b1; data = 16'h1111;
        cyc();
        load = 1'b0;
        repeat (11) cyc();
        load = 1'b1; data = 16'h2222;
        cyc();
        load = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("collide_digit", {12'd0, digit}, 16'd2);
            cyc();
        end

        // Leading-zero blanking
        do_reset();
        blank_lz = 1'b1;
        load = 1'b1; data = 16'h0070;
        cyc();
        load = 1'b0;
        repeat (FRAME - 1) cyc();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("lz70_anodes", {12'd0, anodes}, {12'd0, lz70_tab[i / DIV]});
            cyc();
        end
        load = 1'b1; data = 16'h0000;
        cyc();
        load = 1'b0;
        repeat (FRAME - 1) cyc();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            chk("lz0_anodes", {12'd0, anodes}, (i < DIV) ? 16'h000E : 16'h000F);
            chk("lz0_digit",  {12'd0, digit},  16'd0);
            cyc();
        end
        blank_lz = 1'b0;

        // Enable freeze, then reset discarding pending data
        do_reset();
        repeat (6) cyc();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("en0_anodes", {12'd0, anodes}, 16'h000F);
            cyc();
        end
        en = 1'b1;
        @(negedge clk);
        chk("resume_anodes", {12'd0, anodes}, 16'h000D);
        load = 1'b1; data = 16'h5555;
        cyc();
        load = 1'b0;
        @(negedge clk);
        chk("pre_rst_pending", {15'd0, pending}, 16'd1);
        do_reset();
        @(negedge clk);
        chk("post_rst_anodes",  {12'd0, anodes},  16'h000E);
        chk("post_rst_digit",   {12'd0, digit},   16'd0);
        chk("post_rst_pending", {15'd0, pending}, 16'd0);
        cyc();

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            load     = ($urandom_range(0, 7) == 0);
            data     = 16'($urandom());
            if ($urandom_range(0, 1) == 1)
                data = data >> (4 * $urandom_range(1, 3));
            blank_lz = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
